// File: rtl/accessor.sv
// accessor: memory-access stage between executor and writeback (loads, stores, LUI/ALU pass-through)
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   executor_valid / accessor_ready  op handshake from the executor (accepted only in IDLE)
//   accessor_valid / writeback_ready result handshake towards writeback (valid only in DONE)
//   executor_rd, executor_rd_data, executor_mem_addr, executor_mem_data, executor_is_*  captured op
//   mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata  single-beat word bus
//   accessor_rd, accessor_rd_data, accessor_fault  result towards writeback
module accessor #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        executor_valid,
  output logic        accessor_ready,
  output logic        accessor_valid,
  input  logic        writeback_ready,
  input  logic [4:0]  executor_rd,
  input  logic [31:0] executor_rd_data,
  input  logic [31:0] executor_mem_addr,
  input  logic [31:0] executor_mem_data,
  input  logic        executor_is_lui,
  input  logic        executor_is_lb,
  input  logic        executor_is_lbu,
  input  logic        executor_is_lh,
  input  logic        executor_is_lhu,
  input  logic        executor_is_lw,
  input  logic        executor_is_sb,
  input  logic        executor_is_sh,
  input  logic        executor_is_sw,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  accessor_rd,
  output logic [31:0] accessor_rd_data,
  output logic        accessor_fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [4:0] rd_q;
  logic [1:0] lane, sz;
  logic ld, sx;
  logic accept, is_ld, is_st, mis, bus_op, tmo;
  logic [31:0] pass_val, wdata, shifted, load_val;
  logic [3:0] strb;
  assign accessor_ready = state == IDLE && reset_n;
  assign accessor_valid = state == DONE;
  assign mem_valid = state == BUS;
  always_comb begin
    accept = executor_valid && accessor_ready;
    is_ld = executor_is_lb | executor_is_lbu | executor_is_lh | executor_is_lhu | executor_is_lw;
    is_st = executor_is_sb | executor_is_sh | executor_is_sw;
    mis = ((executor_is_lh | executor_is_lhu | executor_is_sh) & executor_mem_addr[0])
        | ((executor_is_lw | executor_is_sw) & |executor_mem_addr[1:0]);
    bus_op = (is_ld | is_st) & ~mis;
    pass_val = executor_is_lui ? executor_mem_addr : executor_rd_data;
    strb = executor_is_sb ? 4'b0001 << executor_mem_addr[1:0]
         : executor_is_sh ? (executor_mem_addr[1] ? 4'b1100 : 4'b0011)
         : executor_is_sw ? 4'b1111 : 4'b0000;
    wdata = executor_is_sb ? {4{executor_mem_data[7:0]}}
          : executor_is_sh ? {2{executor_mem_data[15:0]}} : executor_mem_data;
    // the addressed byte/half is brought down to bit 0 before extension
    shifted = mem_rdata >> {lane, 3'b000};
    load_val = sz[1] ? shifted
             : sz[0] ? {{16{sx & shifted[15]}}, shifted[15:0]}
             : {{24{sx & shifted[7]}}, shifted[7:0]};
    // mem_ready in the expiring cycle takes priority over the timeout
    tmo = !mem_ready && cnt == CW'(TIMEOUT - 1);
    state_n = state == IDLE ? (accept ? (bus_op ? BUS : DONE) : IDLE)
            : state == BUS ? ((mem_ready || tmo) ? DONE : BUS)
            : (writeback_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      rd_q <= '0;
      lane <= '0;
      sz <= '0;
      ld <= 1'b0;
      sx <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      accessor_rd <= '0;
      accessor_rd_data <= '0;
      accessor_fault <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      rd_q <= executor_rd;
      lane <= executor_mem_addr[1:0];
      sz <= {executor_is_lw, executor_is_lh | executor_is_lhu};
      ld <= is_ld;
      sx <= executor_is_lb | executor_is_lh;
      mem_addr <= {executor_mem_addr[31:2], 2'b00};
      mem_wdata <= wdata;
      mem_wstrb <= strb;
      accessor_rd <= mis ? 5'd0 : executor_rd;
      // bus ops start at 0; loads overwrite it when the read completes
      accessor_rd_data <= (mis || bus_op || executor_rd == 5'd0) ? 32'd0 : pass_val;
      accessor_fault <= mis;
    end else if (state == BUS) begin
      cnt <= cnt + CW'(1);
      if (mem_ready) accessor_rd_data <= (ld && rd_q != 5'd0) ? load_val : 32'd0;
      else if (tmo) begin
        accessor_fault <= 1'b1;
        accessor_rd <= 5'd0;
        accessor_rd_data <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_accessor.sv
// tb_accessor: randomized self-checking bench for accessor against a behavioural model
module tb_accessor;
  localparam int TIMEOUT = 16;
  localparam int ALU = 0, LUI = 1, LB = 2, LBU = 3, LH = 4, LHU = 5, LW = 6, SB = 7, SH = 8, SW = 9;
  logic clk = 0, reset_n = 0, executor_valid = 0, writeback_ready = 0, mem_ready = 0;
  logic [4:0] executor_rd = 0;
  logic [31:0] executor_rd_data = 0, executor_mem_addr = 0, executor_mem_data = 0, mem_rdata = 0;
  logic [9:0] flags = 0;
  logic accessor_ready, accessor_valid, mem_valid, accessor_fault;
  logic [31:0] mem_addr, mem_wdata, accessor_rd_data;
  logic [3:0] mem_wstrb;
  logic [4:0] accessor_rd;
  int total = 0, bad = 0;
  int mem_wait = 0, bus_cyc = 0, mv_cnt = 0;
  logic [31:0] mem_word = 0;
  logic [4:0] exp_rd;
  logic [31:0] exp_data, exp_addr, exp_wdata;
  logic [3:0] exp_strb;
  logic exp_fault, exp_bus, exp_st;
  int exp_mv, exp_lat;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0] seen_strb;
  logic [4:0] r;
  logic [31:0] d;
  logic f;
  int l;

  accessor #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .executor_valid(executor_valid), .accessor_ready(accessor_ready),
    .accessor_valid(accessor_valid), .writeback_ready(writeback_ready), .executor_rd(executor_rd),
    .executor_rd_data(executor_rd_data), .executor_mem_addr(executor_mem_addr),
    .executor_mem_data(executor_mem_data), .executor_is_lui(flags[LUI]), .executor_is_lb(flags[LB]),
    .executor_is_lbu(flags[LBU]), .executor_is_lh(flags[LH]), .executor_is_lhu(flags[LHU]),
    .executor_is_lw(flags[LW]), .executor_is_sb(flags[SB]), .executor_is_sh(flags[SH]),
    .executor_is_sw(flags[SW]), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .accessor_rd(accessor_rd),
    .accessor_rd_data(accessor_rd_data), .accessor_fault(accessor_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic model(input int op, input logic [4:0] rd, input logic [31:0] addr, data, alu, rdata,
                       input int waits);
    int size, lane;
    logic mis, is_ld, is_st, tmo;
    logic [31:0] b, h, db, dh, val;
    size = (op == LH || op == LHU || op == SH) ? 2 : (op == LW || op == SW) ? 4 : 1;
    lane = int'(addr % 32'd4);
    mis = (addr % 32'(size)) != 32'd0;
    is_ld = op >= LB && op <= LW;
    is_st = op >= SB;
    b = (rdata >> (8 * lane)) % 32'd256;
    h = (rdata >> (8 * lane)) % 32'd65536;
    db = data % 32'd256;
    dh = data % 32'd65536;
    exp_bus = (is_ld || is_st) && !mis;
    tmo = exp_bus && waits >= TIMEOUT;
    exp_fault = mis || tmo;
    exp_rd = exp_fault ? 5'd0 : rd;
    val = op == ALU ? alu : op == LUI ? addr
        : op == LB ? (b >= 32'd128 ? b - 32'd256 : b) : op == LBU ? b
        : op == LH ? (h >= 32'd32768 ? h - 32'd65536 : h) : op == LHU ? h
        : op == LW ? rdata : 32'd0;
    exp_data = (exp_fault || rd == 5'd0) ? 32'd0 : val;
    exp_addr = addr - 32'(lane);
    exp_strb = op == SB ? 4'(1 << lane) : op == SH ? (lane >= 2 ? 4'hC : 4'h3) : op == SW ? 4'hF : 4'h0;
    exp_wdata = op == SB ? db * 32'h01010101 : op == SH ? dh * 32'h00010001 : data;
    exp_st = is_st;
    exp_mv = !exp_bus ? 0 : tmo ? TIMEOUT : waits + 1;
    exp_lat = !exp_bus ? 1 : tmo ? TIMEOUT + 1 : waits + 2;
  endtask

  task automatic issue(input int op, input logic [4:0] rd, input logic [31:0] addr, data, alu, rdata,
                       input int waits);
    model(op, rd, addr, data, alu, rdata, waits);
    mem_wait = waits;
    mem_word = rdata;
    mv_cnt = 0;
    executor_valid = 1;
    flags = op == ALU ? 10'd0 : 10'(1 << op);
    executor_rd = rd;
    executor_mem_addr = addr;
    executor_mem_data = data;
    executor_rd_data = alu;
    chk("ready_idle", 32'(accessor_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    executor_valid = 0;
    flags = 10'($urandom) & 10'h3FE;
    executor_rd = 5'($urandom);
    executor_mem_addr = $urandom;
    executor_mem_data = $urandom;
    executor_rd_data = $urandom;
  endtask

  task automatic run_op(input int op, input logic [4:0] rd, input logic [31:0] addr, data, alu, rdata,
                        input int waits, hold, output logic [4:0] o_rd, output logic [31:0] o_data,
                        output logic o_fault, output int o_lat);
    int lat;
    issue(op, rd, addr, data, alu, rdata, waits);
    lat = 1;
    while (!accessor_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("mem_cycles", 32'(mv_cnt), 32'(exp_mv));
    o_rd = accessor_rd;
    o_data = accessor_rd_data;
    o_fault = accessor_fault;
    o_lat = lat;
    repeat (hold) @(negedge clk);
    writeback_ready = 1;
    @(negedge clk);
    writeback_ready = 0;
  endtask

  // bus slave: ready after mem_wait stall cycles, random noise on idle cycles
  always @(negedge clk) begin
    if (mem_valid) begin
      mem_ready = bus_cyc == mem_wait;
      mem_rdata = mem_ready ? mem_word : $urandom;
      bus_cyc++;
    end else begin
      bus_cyc = 0;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
    end
  end

  always @(negedge clk) begin
    if (accessor_valid) begin
      chk("out_rd", 32'(accessor_rd), 32'(exp_rd));
      chk("out_data", accessor_rd_data, exp_data);
      chk("out_fault", 32'(accessor_fault), 32'(exp_fault));
      chk("ready_busy", 32'(accessor_ready), 32'd0);
    end
    if (mem_valid) begin
      mv_cnt++;
      chk("bus_op", 32'(exp_bus), 32'd1);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
      if (exp_st) chk("mem_wdata", mem_wdata, exp_wdata);
      seen_addr = mem_addr;
      seen_wdata = mem_wdata;
      seen_strb = mem_wstrb;
    end
  end

  initial begin
    int op, w;
    logic [4:0] rr;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(accessor_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ready", 32'(accessor_ready), 32'd0);
    chk("rst_data", accessor_rd_data, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_fault", 32'(accessor_fault), 32'd0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_release_ready", 32'(accessor_ready), 32'd1);
    run_op(ALU, 5'd5, 32'h0, 32'h0, 32'h1234, 32'h0, 0, 0, r, d, f, l);
    chk("alu_rd", 32'(r), 32'd5);
    chk("alu_data", d, 32'h1234);
    chk("alu_lat", 32'(l), 32'd1);
    run_op(LB, 5'd7, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 0, 1, r, d, f, l);
    chk("lb_data", d, 32'hFFFFFF80);
    chk("lb_addr", seen_addr, 32'h100);
    chk("lb_wstrb", 32'(seen_strb), 32'd0);
    chk("lb_lat", 32'(l), 32'd2);
    run_op(LBU, 5'd7, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 0, 0, r, d, f, l);
    chk("lbu_data", d, 32'h00000080);
    run_op(SH, 5'd3, 32'h202, 32'hAAAABEEF, 32'h0, 32'h0, 2, 0, r, d, f, l);
    chk("sh_addr", seen_addr, 32'h200);
    chk("sh_wdata", seen_wdata, 32'hBEEFBEEF);
    chk("sh_wstrb", 32'(seen_strb), 32'hC);
    chk("sh_data", d, 32'h0);
    chk("sh_lat", 32'(l), 32'd4);
    run_op(LW, 5'd9, 32'h6, 32'h0, 32'h0, 32'h0, 0, 0, r, d, f, l);
    chk("lw_mis_fault", 32'(f), 32'd1);
    chk("lw_mis_rd", 32'(r), 32'd0);
    run_op(SW, 5'd8, 32'h4, 32'h12345678, 32'h0, 32'h0, 100, 0, r, d, f, l);
    chk("sw_tmo_fault", 32'(f), 32'd1);
    chk("sw_tmo_lat", 32'(l), 32'd17);
    run_op(LW, 5'd2, 32'h8, 32'h0, 32'h0, 32'h5A5A1234, TIMEOUT - 1, 0, r, d, f, l);
    chk("lw_edge_fault", 32'(f), 32'd0);
    chk("lw_edge_data", d, 32'h5A5A1234);
    run_op(LW, 5'd0, 32'hC, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, r, d, f, l);
    chk("lw_rd0_data", d, 32'h0);
    run_op(ALU, 5'd9, 32'h0, 32'h0, 32'hDEAD, 32'h0, 0, 5, r, d, f, l);
    issue(LW, 5'd4, 32'h40, 32'h0, 32'h0, 32'h0, 50);
    repeat (2) @(negedge clk);
    chk("rst_mid_pre", 32'(mem_valid), 32'd1);
    reset_n = 0;
    @(negedge clk);
    chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid_valid", 32'(accessor_valid), 32'd0);
    chk("rst_mid_ready", 32'(accessor_ready), 32'd0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_mid_release", 32'(accessor_ready), 32'd1);
    run_op(LW, 5'd4, 32'h44, 32'h0, 32'h0, 32'hCAFEF00D, 1, 0, r, d, f, l);
    chk("post_rst_lw", d, 32'hCAFEF00D);
    repeat (80) begin
      op = $urandom_range(0, 9);
      rr = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      w = $urandom % 8;
      w = w == 0 ? TIMEOUT - 1 : w == 1 ? TIMEOUT : w % 3;
      run_op(op, rr, $urandom, $urandom, $urandom, $urandom, w, $urandom % 3, r, d, f, l);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
